// File: rtl/uart_core_ex.sv
// uart_core_ex: full-duplex UART with configurable framing, 16x oversampled
// receive, first-word-fall-through RX FIFO and sticky error flags.
//
// TX FSM
//   state     | meaning
//   TX_IDLE   | line high, tx_ready asserted, waiting for tx_valid
//   TX_START  | driving the start bit (low)
//   TX_DATA   | shifting data bits out, LSB first
//   TX_PARITY | driving the parity bit (only when parity is enabled)
//   TX_STOP   | holding the line high for STOP_BITS bit times
//
// RX FSM
//   state     | meaning
//   RX_IDLE   | waiting for a falling edge on the synchronised line
//   RX_START  | start bit, re-checked mid-bit to reject glitches
//   RX_DATA   | sampling data bits mid-bit, LSB first
//   RX_PARITY | sampling and checking the parity bit
//   RX_STOP   | sampling the first stop bit, then push or flag
//   RX_BREAK  | frame error seen, waiting for the line to return high
module uart_core_ex #(
  parameter int DATA_WIDTH    = 8,
  parameter int PARITY_MODE   = 0,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [15:0]                        baud_div,
  input  logic [DATA_WIDTH-1:0]              tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  output logic                               uart_tx,
  output logic [DATA_WIDTH-1:0]              rx_data,
  output logic                               rx_valid,
  input  logic                               rx_ready,
  input  logic                               uart_rx,
  output logic [$clog2(RX_FIFO_DEPTH):0]     rx_level,
  output logic                               tx_busy,
  output logic                               rx_busy,
  output logic                               frame_error,
  output logic                               parity_error,
  output logic                               overrun_error,
  input  logic                               err_clr
);

  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [3:0] LAST_IDX = 4'(DATA_WIDTH - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);
  localparam logic PAR_ODD = (PARITY_MODE == 2);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

  logic [1:0]  rst_pipe;
  logic        rst_n_sync;
  logic [15:0] div_m1;

  // Reset asserts immediately and releases two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n_sync = rst_pipe[1];

  // A divisor of zero behaves as one.
  assign div_m1 = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;

  // ---------------------------------------------------------------- TX
  tx_state_t             tx_state_q, tx_state_d;
  logic [15:0]           tx_div_q;
  logic [3:0]            tx_tick_q;
  logic [3:0]            tx_idx_q, tx_idx_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  tx_stop_q, tx_stop_d;
  logic                  tx_par_q;
  logic                  uart_tx_q, uart_tx_d;
  logic                  tx_start, tx_tick, tx_bit_end;

  assign tx_start   = (tx_state_q == TX_IDLE) && tx_valid;
  assign tx_tick    = (tx_div_q == 16'd0);
  assign tx_bit_end = tx_tick && (tx_tick_q == 4'd15);

  // TX next-state and next line value; the line itself is registered.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_idx_d   = tx_idx_q;
    tx_stop_d  = tx_stop_q;
    uart_tx_d  = uart_tx_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_state_d = TX_START;
          tx_shift_d = tx_data;
          uart_tx_d  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_idx_d   = 4'd0;
          uart_tx_d  = tx_shift_q[0];
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          if (tx_idx_q == LAST_IDX) begin
            tx_stop_d = 1'b0;
            if (PARITY_MODE != 0) begin
              tx_state_d = TX_PARITY;
              uart_tx_d  = tx_par_q;
            end else begin
              tx_state_d = TX_STOP;
              uart_tx_d  = 1'b1;
            end
          end else begin
            tx_idx_d   = tx_idx_q + 4'd1;
            tx_shift_d = tx_shift_q >> 1;
            uart_tx_d  = tx_shift_q[1];
          end
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) begin
          tx_state_d = TX_STOP;
          uart_tx_d  = 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_stop_q == LAST_STOP) tx_state_d = TX_IDLE;
          else                        tx_stop_d  = 1'b1;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        uart_tx_d  = 1'b1;
      end
    endcase
  end

  // TX state register, divider (restarted on handshake) and parity latch.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      tx_state_q <= TX_IDLE;
      tx_div_q   <= 16'd0;
      tx_tick_q  <= 4'd0;
      tx_idx_q   <= 4'd0;
      tx_shift_q <= '0;
      tx_stop_q  <= 1'b0;
      tx_par_q   <= 1'b0;
      uart_tx_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_stop_q  <= tx_stop_d;
      uart_tx_q  <= uart_tx_d;
      if (tx_start) begin
        tx_div_q  <= div_m1;
        tx_tick_q <= 4'd0;
        tx_par_q  <= (^tx_data) ^ PAR_ODD;
      end else if (tx_tick) begin
        tx_div_q  <= div_m1;
        tx_tick_q <= tx_tick_q + 4'd1;
      end else begin
        tx_div_q  <= tx_div_q - 16'd1;
      end
    end
  end

  assign uart_tx  = uart_tx_q;
  assign tx_ready = (tx_state_q == TX_IDLE);
  assign tx_busy  = (tx_state_q != TX_IDLE);

  // ---------------------------------------------------------------- RX
  rx_state_t             rx_state_q, rx_state_d;
  logic                  rx_meta, rx_sync, rx_prev;
  logic [15:0]           rx_div_q;
  logic [3:0]            rx_tick_q;
  logic [3:0]            rx_idx_q, rx_idx_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic                  rx_par_bad_q, rx_par_bad_d;
  logic                  rx_push_q, rx_push_d;
  logic                  set_fe, set_pe, set_oe;
  logic                  rx_fall, rx_tick, rx_sample, rx_bit_end;

  assign rx_fall    = rx_prev && !rx_sync;
  assign rx_tick    = (rx_div_q == 16'd0);
  assign rx_sample  = rx_tick && (rx_tick_q == 4'd7);
  assign rx_bit_end = rx_tick && (rx_tick_q == 4'd15);

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX next-state, mid-bit sampling and frame/parity verdicts.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_idx_d     = rx_idx_q;
    rx_shift_d   = rx_shift_q;
    rx_par_bad_d = rx_par_bad_q;
    rx_push_d    = 1'b0;
    set_fe       = 1'b0;
    set_pe       = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d   = RX_START;
          rx_par_bad_d = 1'b0;
        end
      end
      RX_START: begin
        if (rx_sample && rx_sync) begin
          rx_state_d = RX_IDLE;
        end else if (rx_bit_end) begin
          rx_state_d = RX_DATA;
          rx_idx_d   = 4'd0;
        end
      end
      RX_DATA: begin
        if (rx_sample) rx_shift_d = {rx_sync, rx_shift_q[DATA_WIDTH-1:1]};
        if (rx_bit_end) begin
          if (rx_idx_q == LAST_IDX) rx_state_d = (PARITY_MODE != 0) ? RX_PARITY : RX_STOP;
          else                      rx_idx_d   = rx_idx_q + 4'd1;
        end
      end
      RX_PARITY: begin
        if (rx_sample) begin
          rx_par_bad_d = (rx_sync != ((^rx_shift_q) ^ PAR_ODD));
          set_pe       = rx_par_bad_d;
        end
        if (rx_bit_end) rx_state_d = RX_STOP;
      end
      RX_STOP: begin
        if (rx_sample) begin
          if (!rx_sync) begin
            set_fe     = 1'b1;
            rx_state_d = RX_BREAK;
          end else begin
            rx_state_d = RX_IDLE;
            rx_push_d  = !rx_par_bad_q;
          end
        end
      end
      RX_BREAK: begin
        if (rx_sync) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX state register and divider, restarted on the start-bit edge.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      rx_state_q   <= RX_IDLE;
      rx_div_q     <= 16'd0;
      rx_tick_q    <= 4'd0;
      rx_idx_q     <= 4'd0;
      rx_shift_q   <= '0;
      rx_par_bad_q <= 1'b0;
      rx_push_q    <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_idx_q     <= rx_idx_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_bad_q <= rx_par_bad_d;
      rx_push_q    <= rx_push_d;
      if ((rx_state_q == RX_IDLE) && rx_fall) begin
        rx_div_q  <= div_m1;
        rx_tick_q <= 4'd0;
      end else if (rx_tick) begin
        rx_div_q  <= div_m1;
        rx_tick_q <= rx_tick_q + 4'd1;
      end else begin
        rx_div_q  <= rx_div_q - 16'd1;
      end
    end
  end

  assign rx_busy = (rx_state_q == RX_START) || (rx_state_q == RX_DATA) ||
                   (rx_state_q == RX_PARITY) || (rx_state_q == RX_STOP);

  // ---------------------------------------------------------------- FIFO
  logic [DATA_WIDTH-1:0] fifo_mem [RX_FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         count_q;
  logic                  fifo_full, do_pop, do_push;

  // rx_shift_q is stable in the cycle after the stop sample, so it is the push data.
  assign fifo_full = (count_q == LW'(RX_FIFO_DEPTH));
  assign do_pop    = rx_valid && rx_ready;
  assign do_push   = rx_push_q && (!fifo_full || do_pop);
  assign set_oe    = rx_push_q && fifo_full && !do_pop;

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr_q] <= rx_shift_q;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + LW'(1);
      else if (do_pop && !do_push) count_q <= count_q - LW'(1);
    end
  end

  assign rx_valid = (count_q != '0);
  assign rx_level = count_q;
  assign rx_data  = rx_valid ? fifo_mem[rd_ptr_q] : '0;

  // Sticky error flags; a new error in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      frame_error   <= 1'b0;
      parity_error  <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      if (set_fe)       frame_error   <= 1'b1;
      else if (err_clr) frame_error   <= 1'b0;
      if (set_pe)       parity_error  <= 1'b1;
      else if (err_clr) parity_error  <= 1'b0;
      if (set_oe)       overrun_error <= 1'b1;
      else if (err_clr) overrun_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_core_ex.sv
// Directed testbench for uart_core_ex: instance A is 8N1 with a bench-driven
// RX line, instance B is 8E2 with TX looped back into its own RX.
module tb_uart_core_ex;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] baud_div = 16'd2;

  logic [7:0] tx_data_a = 8'h00, rx_data_a;
  logic       tx_valid_a = 1'b0, tx_ready_a, uart_tx_a, rx_valid_a;
  logic       rx_ready_a = 1'b0, uart_rx_a = 1'b1, tx_busy_a, rx_busy_a;
  logic       fe_a, pe_a, oe_a, err_clr_a = 1'b0;
  logic [2:0] rx_level_a;

  logic [7:0] tx_data_b = 8'h00, rx_data_b;
  logic       tx_valid_b = 1'b0, tx_ready_b, uart_tx_b, rx_valid_b;
  logic       rx_ready_b = 1'b0, tx_busy_b, rx_busy_b;
  logic       fe_b, pe_b, oe_b, err_clr_b = 1'b0;
  logic [2:0] rx_level_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_core_ex #(.DATA_WIDTH(8), .PARITY_MODE(0), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .uart_tx(uart_tx_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .uart_rx(uart_rx_a),
    .rx_level(rx_level_a), .tx_busy(tx_busy_a), .rx_busy(rx_busy_a),
    .frame_error(fe_a), .parity_error(pe_a), .overrun_error(oe_a), .err_clr(err_clr_a)
  );

  uart_core_ex #(.DATA_WIDTH(8), .PARITY_MODE(1), .STOP_BITS(2), .RX_FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .uart_tx(uart_tx_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .uart_rx(uart_tx_b),
    .rx_level(rx_level_b), .tx_busy(tx_busy_b), .rx_busy(rx_busy_b),
    .frame_error(fe_b), .parity_error(pe_b), .overrun_error(oe_b), .err_clr(err_clr_b)
  );

  // Bit-bang one 8N1 frame onto instance A's RX line, 32 clocks per bit.
  task automatic drive_rx_a(input logic [7:0] d, input logic stop_val);
    logic [9:0] fr;
    fr = {stop_val, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      uart_rx_a = fr[b];
      repeat (32) @(negedge clk);
    end
    uart_rx_a = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++; if (uart_tx_a !== 1'b1) begin miscompares++; $display("FAIL reset_uart_tx got %b want 1", uart_tx_a); end
    vectors++; if (tx_ready_a !== 1'b1) begin miscompares++; $display("FAIL reset_tx_ready got %b want 1", tx_ready_a); end
    vectors++; if (tx_busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_tx_busy got %b want 0", tx_busy_a); end
    vectors++; if (rx_valid_a !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid got %b want 0", rx_valid_a); end
    vectors++; if (rx_level_a !== 3'd0) begin miscompares++; $display("FAIL reset_rx_level got %0d want 0", rx_level_a); end
    vectors++; if (rx_busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_rx_busy got %b want 0", rx_busy_a); end
    vectors++; if (rx_data_a !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data got %h want 00", rx_data_a); end
    vectors++; if ({fe_a, pe_a, oe_a} !== 3'b000) begin miscompares++; $display("FAIL reset_errors got %b want 000", {fe_a, pe_a, oe_a}); end
    vectors++; if (uart_tx_b !== 1'b1) begin miscompares++; $display("FAIL reset_uart_tx_b got %b want 1", uart_tx_b); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    vectors++; if (tx_ready_a !== 1'b1 || uart_tx_a !== 1'b1) begin miscompares++; $display("FAIL post_reset_idle got ready=%b tx=%b want 1 1", tx_ready_a, uart_tx_a); end
  endtask

  // One 8N1 frame from instance A, checked every clock against the bit table.
  task automatic test_tx_frame_a(input logic [7:0] d);
    logic [9:0] fr;
    logic       exp_tx;
    int         n;
    fr = {1'b1, d, 1'b0};
    n = 0;
    while (!tx_ready_a && n < 1000) begin @(negedge clk); n++; end
    vectors++; if (tx_ready_a !== 1'b1) begin miscompares++; $display("FAIL tx_ready_wait got %b want 1", tx_ready_a); end
    tx_data_a = d; tx_valid_a = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b0;
    for (int k = 0; k < 340; k++) begin
      if (k == 100) begin tx_data_a = ~d; tx_valid_a = 1'b1; end
      if (k == 101) tx_valid_a = 1'b0;
      exp_tx = (k < 320) ? fr[k / 32] : 1'b1;
      vectors++; if (uart_tx_a !== exp_tx) begin miscompares++; $display("FAIL tx_bit d=%h clk=%0d got %b want %b", d, k, uart_tx_a, exp_tx); end
      vectors++; if (tx_busy_a !== (k < 320)) begin miscompares++; $display("FAIL tx_busy d=%h clk=%0d got %b want %b", d, k, tx_busy_a, (k < 320)); end
      vectors++; if (tx_ready_a !== (k >= 320)) begin miscompares++; $display("FAIL tx_ready d=%h clk=%0d got %b want %b", d, k, tx_ready_a, (k >= 320)); end
      @(negedge clk);
    end
  endtask

  task automatic test_tx_basic();
    test_tx_frame_a(8'hA5);
  endtask

  task automatic test_parity_loopback();
    logic [7:0]  words [2];
    logic        pars  [2];
    logic [11:0] fr;
    int          n;
    words[0] = 8'h07; pars[0] = 1'b1;
    words[1] = 8'h00; pars[1] = 1'b0;
    n = 0;
    while (!tx_ready_b && n < 1000) begin @(negedge clk); n++; end
    for (int w = 0; w < 2; w++) begin
      fr = {2'b11, pars[w], words[w], 1'b0};
      tx_data_b = words[w]; tx_valid_b = 1'b1;
      @(negedge clk);
      tx_valid_b = 1'b0;
      for (int k = 0; k < 384; k++) begin
        vectors++; if (uart_tx_b !== fr[k / 32]) begin miscompares++; $display("FAIL par_frame d=%h clk=%0d got %b want %b", words[w], k, uart_tx_b, fr[k / 32]); end
        vectors++; if (tx_busy_b !== 1'b1) begin miscompares++; $display("FAIL par_busy d=%h clk=%0d got %b want 1", words[w], k, tx_busy_b); end
        @(negedge clk);
      end
      vectors++; if (tx_ready_b !== 1'b1 || tx_busy_b !== 1'b0) begin miscompares++; $display("FAIL par_len d=%h got ready=%b busy=%b want 1 0", words[w], tx_ready_b, tx_busy_b); end
    end
    repeat (10) @(negedge clk);
    vectors++; if (rx_level_b !== 3'd2) begin miscompares++; $display("FAIL loop_level got %0d want 2", rx_level_b); end
    vectors++; if (rx_data_b !== 8'h07) begin miscompares++; $display("FAIL loop_word0 got %h want 07", rx_data_b); end
    rx_ready_b = 1'b1; @(negedge clk); rx_ready_b = 1'b0;
    vectors++; if (rx_data_b !== 8'h00 || rx_level_b !== 3'd1) begin miscompares++; $display("FAIL loop_word1 got %h lvl %0d want 00 lvl 1", rx_data_b, rx_level_b); end
    rx_ready_b = 1'b1; @(negedge clk); rx_ready_b = 1'b0;
    vectors++; if (rx_valid_b !== 1'b0 || rx_level_b !== 3'd0) begin miscompares++; $display("FAIL loop_empty got valid=%b lvl=%0d want 0 0", rx_valid_b, rx_level_b); end
    vectors++; if ({fe_b, pe_b, oe_b} !== 3'b000) begin miscompares++; $display("FAIL loop_errors got %b want 000", {fe_b, pe_b, oe_b}); end
  endtask

  task automatic test_overrun();
    logic [7:0] words [5];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44; words[4] = 8'h55;
    rx_ready_a = 1'b0;
    for (int i = 0; i < 5; i++) drive_rx_a(words[i], 1'b1);
    vectors++; if (rx_level_a !== 3'd4) begin miscompares++; $display("FAIL ovr_level got %0d want 4", rx_level_a); end
    vectors++; if (oe_a !== 1'b1) begin miscompares++; $display("FAIL ovr_flag got %b want 1", oe_a); end
    vectors++; if (fe_a !== 1'b0 || pe_a !== 1'b0) begin miscompares++; $display("FAIL ovr_other_flags got fe=%b pe=%b want 0 0", fe_a, pe_a); end
    err_clr_a = 1'b1; @(negedge clk); err_clr_a = 1'b0;
    vectors++; if (oe_a !== 1'b0) begin miscompares++; $display("FAIL ovr_clear got %b want 0", oe_a); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (rx_data_a !== words[i]) begin miscompares++; $display("FAIL ovr_pop%0d got %h want %h", i, rx_data_a, words[i]); end
      rx_ready_a = 1'b1; @(negedge clk); rx_ready_a = 1'b0;
    end
    vectors++; if (rx_level_a !== 3'd0 || rx_valid_a !== 1'b0) begin miscompares++; $display("FAIL ovr_drained got lvl=%0d valid=%b want 0 0", rx_level_a, rx_valid_a); end
  endtask

  task automatic test_frame_error();
    logic seen;
    drive_rx_a(8'h3C, 1'b0);
    vectors++; if (fe_a !== 1'b1) begin miscompares++; $display("FAIL fe_set got %b want 1", fe_a); end
    vectors++; if (rx_level_a !== 3'd0) begin miscompares++; $display("FAIL fe_level got %0d want 0", rx_level_a); end
    vectors++; if (pe_a !== 1'b0 || oe_a !== 1'b0) begin miscompares++; $display("FAIL fe_other_flags got pe=%b oe=%b want 0 0", pe_a, oe_a); end
    err_clr_a = 1'b1; @(negedge clk); err_clr_a = 1'b0;
    vectors++; if (fe_a !== 1'b0) begin miscompares++; $display("FAIL fe_clear got %b want 0", fe_a); end
    drive_rx_a(8'h55, 1'b1);
    vectors++; if (rx_level_a !== 3'd1 || rx_data_a !== 8'h55) begin miscompares++; $display("FAIL fe_recover got lvl=%0d data=%h want 1 55", rx_level_a, rx_data_a); end
    vectors++; if (fe_a !== 1'b0) begin miscompares++; $display("FAIL fe_recover_flag got %b want 0", fe_a); end
    rx_ready_a = 1'b1; @(negedge clk); rx_ready_a = 1'b0;
    // err_clr held through a bad frame: the set must still be visible for a cycle.
    seen = 1'b0;
    err_clr_a = 1'b1;
    fork
      drive_rx_a(8'h3C, 1'b0);
      for (int k = 0; k < 336; k++) begin
        if (fe_a === 1'b1) seen = 1'b1;
        @(negedge clk);
      end
    join
    err_clr_a = 1'b0;
    vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL fe_set_wins got %b want 1", seen); end
    vectors++; if (fe_a !== 1'b0) begin miscompares++; $display("FAIL fe_held_clear got %b want 0", fe_a); end
  endtask

  task automatic test_false_start();
    logic seen;
    seen = 1'b0;
    vectors++; if (rx_busy_a !== 1'b0) begin miscompares++; $display("FAIL fs_idle got %b want 0", rx_busy_a); end
    uart_rx_a = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (k == 8) uart_rx_a = 1'b1;
      if (rx_busy_a === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL fs_busy_pulse got %b want 1", seen); end
    vectors++; if (rx_busy_a !== 1'b0) begin miscompares++; $display("FAIL fs_busy_end got %b want 0", rx_busy_a); end
    vectors++; if (rx_level_a !== 3'd0) begin miscompares++; $display("FAIL fs_level got %0d want 0", rx_level_a); end
    vectors++; if ({fe_a, pe_a, oe_a} !== 3'b000) begin miscompares++; $display("FAIL fs_flags got %b want 000", {fe_a, pe_a, oe_a}); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    n = 0;
    while (!tx_ready_a && n < 1000) begin @(negedge clk); n++; end
    tx_data_a = 8'h00; tx_valid_a = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b0;
    repeat (5 * 32 + 10) @(negedge clk);
    vectors++; if (uart_tx_a !== 1'b0) begin miscompares++; $display("FAIL mid_frame_low got %b want 0", uart_tx_a); end
    rst_n = 1'b0;
    #1;
    vectors++; if (uart_tx_a !== 1'b1) begin miscompares++; $display("FAIL rst_uart_tx got %b want 1", uart_tx_a); end
    vectors++; if (tx_ready_a !== 1'b1 || tx_busy_a !== 1'b0) begin miscompares++; $display("FAIL rst_tx_state got ready=%b busy=%b want 1 0", tx_ready_a, tx_busy_a); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    test_tx_frame_a(8'h81);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tx_basic();
    test_parity_loopback();
    test_overrun();
    test_frame_error();
    test_false_start();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
